// File: rtl/chacha_pkg.sv
// chacha_pkg: shared types, constants and helpers for the ChaCha keystream generator.
// Build option CHACHA_COUNTER64_EN: when defined, the block counter is 64 bits wide
// and occupies state words 12 (lo) and 13 (hi). When undefined, the IETF layout is used:
// a 32-bit counter in word 12 and a 96-bit nonce in words 13..15.
package chacha_pkg;

  typedef logic [31:0]  word_t;
  typedef word_t [0:15] state_t;
  typedef word_t [0:7]  key_t;
  typedef word_t [0:2]  nonce_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_ADD,
    ST_WAIT
  } ks_state_e;

  // "expand 32-byte k"
  localparam word_t [0:3] SIGMA = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

  // Quarter-round word indices: entries 0..3 are the column round, 4..7 the diagonal round.
  localparam logic [0:7][0:3][3:0] QR_IDX = {
    4'd0, 4'd4, 4'd8,  4'd12,
    4'd1, 4'd5, 4'd9,  4'd13,
    4'd2, 4'd6, 4'd10, 4'd14,
    4'd3, 4'd7, 4'd11, 4'd15,
    4'd0, 4'd5, 4'd10, 4'd15,
    4'd1, 4'd6, 4'd11, 4'd12,
    4'd2, 4'd7, 4'd8,  4'd13,
    4'd3, 4'd4, 4'd9,  4'd14
  };

  // Last counter value a stream may use before it ends.
`ifdef CHACHA_COUNTER64_EN
  localparam logic [63:0] CTR_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [63:0] CTR_MAX = 64'h0000_0000_FFFF_FFFF;
`endif

  function automatic bit rounds_legal(int unsigned r);
    return (r == 8) || (r == 12) || (r == 20);
  endfunction

  function automatic bit qrpc_legal(int unsigned q);
    return (q == 1) || (q == 2) || (q == 4);
  endfunction

  function automatic word_t rotl(word_t x, int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// chacha_qr: combinational ChaCha quarter round on four words (rotates 16, 12, 8, 7).
// Ports: a_i..d_i input words, a_o..d_o updated words.
module chacha_qr
  import chacha_pkg::*;
(
  input  word_t a_i,
  input  word_t b_i,
  input  word_t c_i,
  input  word_t d_i,
  output word_t a_o,
  output word_t b_o,
  output word_t c_o,
  output word_t d_o
);

  word_t a1, b1, c1, d1, a2, c2, d2;

  always_comb begin
    a1  = a_i + b_i;
    d1  = rotl(d_i ^ a1, 16);
    c1  = c_i + d1;
    b1  = rotl(b_i ^ c1, 12);
    a2  = a1 + b1;
    d2  = rotl(d1 ^ a2, 8);
    c2  = c1 + d2;
    a_o = a2;
    b_o = rotl(b1 ^ c2, 7);
    c_o = c2;
    d_o = d2;
  end

endmodule

// File: rtl/chacha_keystream.sv
// chacha_keystream: streaming ChaCha keystream generator with one output buffer.
// Loads key/nonce/counter on cfg_valid & cfg_ready, then produces consecutive 512-bit
// blocks on ks_valid/ks_ready, stepping the counter once per block handed to the buffer.
// Ports: clk, rst (sync, active high); cfg_valid/cfg_ready with key, nonce, ctr_init;
//   stop aborts a stream; ks_valid/ks_ready/ks_data/ks_ctr output stream; ctr_wrap sticky
//   flag set when a stream ends at counter exhaustion.
// Build option CHACHA_COUNTER64_EN selects the 64-bit counter layout (see chacha_pkg).
module chacha_keystream
  import chacha_pkg::*;
#(
  parameter int unsigned ROUNDS       = 20,
  parameter int unsigned QR_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  key_t        key,
  input  nonce_t      nonce,
  input  logic [63:0] ctr_init,
  input  logic        stop,
  output logic        ks_valid,
  input  logic        ks_ready,
  output state_t      ks_data,
  output logic [63:0] ks_ctr,
  output logic        ctr_wrap
);

  localparam int unsigned NSTEP  = ROUNDS * 4 / QR_PER_CYCLE;
  localparam int unsigned SPD    = 8 / QR_PER_CYCLE;  // round steps per double round
  localparam int unsigned STEP_W = $clog2(NSTEP);

  if (!rounds_legal(ROUNDS)) begin : g_bad_rounds
    $error("chacha_keystream: ROUNDS must be 8, 12 or 20");
  end
  if (!qrpc_legal(QR_PER_CYCLE)) begin : g_bad_qrpc
    $error("chacha_keystream: QR_PER_CYCLE must be 1, 2 or 4");
  end

  ks_state_e          state_q;
  key_t               key_q;
  nonce_t             nonce_q;
  logic [63:0]        ctr_q;
  state_t             ws_q;
  logic [STEP_W-1:0]  step_q;
  logic               cfg_ready_q, ks_valid_q, ctr_wrap_q;
  state_t             ks_data_q;
  logic [63:0]        ks_ctr_q;

  state_t             in_state_d, ws_rnd_d, sum_d;
  logic [63:0]        ctr_in;
  logic               buf_free;
  int unsigned        sel_base;
  logic [3:0]         qidx [QR_PER_CYCLE][4];
  word_t [0:3]        qin  [QR_PER_CYCLE];
  word_t [0:3]        qout [QR_PER_CYCLE];

`ifdef CHACHA_COUNTER64_EN
  logic unused_nonce0;
  assign ctr_in        = ctr_init;
  assign unused_nonce0 = ^nonce_q[0];
`else
  logic unused_ctr_hi;
  assign ctr_in        = {32'h0, ctr_init[31:0]};
  assign unused_ctr_hi = ^ctr_init[63:32];
`endif

  // Block input state built from the latched configuration and current counter.
  always_comb begin
    in_state_d        = '0;
    in_state_d[0:3]   = SIGMA;
    in_state_d[4:11]  = key_q;
    in_state_d[12]    = ctr_q[31:0];
`ifdef CHACHA_COUNTER64_EN
    in_state_d[13]    = ctr_q[63:32];
    in_state_d[14:15] = nonce_q[1:2];
`else
    in_state_d[13:15] = nonce_q;
`endif
  end

  // Pick this step's quarter rounds; QR_PER_CYCLE divides 4, so one step never
  // mixes column and diagonal groups and the selected word sets are disjoint.
  always_comb begin
    sel_base = (32'(step_q) % SPD) * QR_PER_CYCLE;
    for (int j = 0; j < int'(QR_PER_CYCLE); j++) begin
      for (int k = 0; k < 4; k++) begin
        qidx[j][k] = QR_IDX[3'(sel_base + 32'(j))][k];
        qin[j][k]  = ws_q[qidx[j][k]];
      end
    end
  end

  for (genvar j = 0; j < int'(QR_PER_CYCLE); j++) begin : g_qr
    chacha_qr u_qr (
      .a_i (qin[j][0]),
      .b_i (qin[j][1]),
      .c_i (qin[j][2]),
      .d_i (qin[j][3]),
      .a_o (qout[j][0]),
      .b_o (qout[j][1]),
      .c_o (qout[j][2]),
      .d_o (qout[j][3])
    );
  end

  // Scatter quarter-round results back into the working state.
  always_comb begin
    ws_rnd_d = ws_q;
    for (int j = 0; j < int'(QR_PER_CYCLE); j++) begin
      for (int k = 0; k < 4; k++) begin
        ws_rnd_d[qidx[j][k]] = qout[j][k];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sum_d[i] = ws_q[i] + in_state_d[i];
    end
  end

  // Buffer can take a new block if empty or being drained this cycle.
  assign buf_free = !ks_valid_q || ks_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_ready_q <= 1'b1;
      ks_valid_q  <= 1'b0;
      ks_data_q   <= '0;
      ks_ctr_q    <= '0;
      ctr_wrap_q  <= 1'b0;
      key_q       <= '0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      ws_q        <= '0;
      step_q      <= '0;
    end else begin
      if (ks_valid_q && ks_ready) begin
        ks_valid_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            key_q       <= key;
            nonce_q     <= nonce;
            ctr_q       <= ctr_in;
            cfg_ready_q <= 1'b0;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          ws_q       <= in_state_d;
          step_q     <= '0;
          ctr_wrap_q <= 1'b0;
          state_q    <= ST_ROUND;
        end
        ST_ROUND: begin
          ws_q   <= ws_rnd_d;
          step_q <= step_q + STEP_W'(1);
          if (step_q == STEP_W'(NSTEP - 1)) begin
            state_q <= ST_ADD;
          end
        end
        ST_ADD, ST_WAIT: begin
          // ws_q and ctr_q are held in WAIT, so sum_d stays valid until the buffer frees.
          if (buf_free) begin
            ks_valid_q <= 1'b1;
            ks_data_q  <= sum_d;
            ks_ctr_q   <= ctr_q;
            if (ctr_q == CTR_MAX) begin
              ctr_wrap_q  <= 1'b1;
              cfg_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              ctr_q   <= ctr_q + 64'd1;
              state_q <= ST_LOAD;
            end
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: begin
          cfg_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
      // Abort overrides everything above, including a block landing this cycle.
      if (stop && (state_q != ST_IDLE)) begin
        state_q     <= ST_IDLE;
        cfg_ready_q <= 1'b1;
        ks_valid_q  <= 1'b0;
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign ks_valid  = ks_valid_q;
  assign ks_data   = ks_data_q;
  assign ks_ctr    = ks_ctr_q;
  assign ctr_wrap  = ctr_wrap_q;

endmodule

// File: tb/tb_chacha_keystream.sv
// tb_chacha_keystream: randomized self-checking bench for chacha_keystream against a
// behavioural ChaCha block function; also covers the RFC 8439 vector, backpressure,
// stop/reset aborts and counter wrap (or 64-bit carry when CHACHA_COUNTER64_EN is set).
module tb_chacha_keystream;
  import chacha_pkg::*;

  localparam int unsigned ROUNDS = 20;
  localparam int unsigned QRPC   = 4;
  localparam int          LAT    = int'(ROUNDS * 4 / QRPC) + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  key_t        key = '0;
  nonce_t      nonce = '0;
  logic [63:0] ctr_init = '0;
  logic        stop = 1'b0;
  logic        ks_valid;
  logic        ks_ready = 1'b0;
  state_t      ks_data;
  logic [63:0] ks_ctr;
  logic        ctr_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  state_t      got_data[$];
  logic [63:0] got_ctr[$];

  always #5 clk = ~clk;

  chacha_keystream #(.ROUNDS(ROUNDS), .QR_PER_CYCLE(QRPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .key       (key),
    .nonce     (nonce),
    .ctr_init  (ctr_init),
    .stop      (stop),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .ks_data   (ks_data),
    .ks_ctr    (ks_ctr),
    .ctr_wrap  (ctr_wrap)
  );

  // Consumer side: record every block the consumer accepts.
  always @(negedge clk) begin
    if (!rst && ks_valid && ks_ready) begin
      got_data.push_back(ks_data);
      got_ctr.push_back(ks_ctr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic word_t rl(word_t v, int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic state_t qr(state_t x, int a, int b, int c, int d);
    x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 16);
    x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 12);
    x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 8);
    x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 7);
    return x;
  endfunction

  function automatic state_t ref_block(key_t k, nonce_t n, logic [63:0] c);
    state_t s, x;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[i];
    s[12] = c[31:0];
`ifdef CHACHA_COUNTER64_EN
    s[13] = c[63:32]; s[14] = n[1]; s[15] = n[2];
`else
    s[13] = n[0]; s[14] = n[1]; s[15] = n[2];
`endif
    x = s;
    for (int r = 0; r < int'(ROUNDS / 2); r++) begin
      x = qr(x, 0, 4, 8, 12); x = qr(x, 1, 5, 9, 13); x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
      x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12); x = qr(x, 2, 7, 8, 13); x = qr(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) x[i] = x[i] + s[i];
    return x;
  endfunction

  function automatic logic [63:0] ctr_of(logic [63:0] c);
`ifdef CHACHA_COUNTER64_EN
    return c;
`else
    return {32'h0, c[31:0]};
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input string tag, input key_t k, input nonce_t n, input logic [63:0] c);
    check({tag, "_cfg_ready"}, 512'(cfg_ready), 512'(1'b1));
    key = k; nonce = n; ctr_init = c; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    key = '0; nonce = '0; ctr_init = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!ks_valid && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 512'(n), 512'(LAT));
  endtask

  task automatic wait_blocks(input string tag, input int nb, input int budget);
    int n = 0;
    while (got_ctr.size() < nb && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_arrived"}, 512'(got_ctr.size() >= nb), 512'(1'b1));
  endtask

  task automatic stop_stream(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check({tag, "_stop_valid"}, 512'(ks_valid), 512'(1'b0));
    check({tag, "_stop_ready"}, 512'(cfg_ready), 512'(1'b1));
  endtask

  task automatic check_stream(input string tag, input key_t k, input nonce_t n,
                              input logic [63:0] c0, input int nb);
    check({tag, "_count"}, 512'(got_ctr.size()), 512'(nb));
    for (int i = 0; i < got_ctr.size(); i++) begin
      check($sformatf("%s_ctr%0d", tag, i), 512'(got_ctr[i]), 512'(ctr_of(c0 + 64'(i))));
      check($sformatf("%s_data%0d", tag, i), got_data[i], ref_block(k, n, c0 + 64'(i)));
    end
    got_ctr.delete();
    got_data.delete();
  endtask

  task automatic rand_cfg(output key_t k, output nonce_t n);
    for (int i = 0; i < 8; i++) k[i] = $urandom;
    for (int i = 0; i < 3; i++) n[i] = $urandom;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    key_t        rfc_k, rk;
    nonce_t      rfc_n, rn;
    logic [63:0] c;
    state_t      held;
    logic        hold_bad;
    int          n;

    for (int i = 0; i < 8; i++) rfc_k[i] = 32'h03020100 + 32'(i) * 32'h04040404;
    rfc_n[0] = 32'h09000000; rfc_n[1] = 32'h4a000000; rfc_n[2] = 32'h00000000;

    // Reset, with cfg_valid asserted to show reset dominates.
    rst = 1'b1; cfg_valid = 1'b1;
    repeat (3) tick();
    check("rst_cfg_ready", 512'(cfg_ready), 512'(1'b1));
    check("rst_ks_valid",  512'(ks_valid),  512'(1'b0));
    check("rst_ks_data",   ks_data,         512'(0));
    check("rst_ks_ctr",    512'(ks_ctr),    512'(0));
    check("rst_ctr_wrap",  512'(ctr_wrap),  512'(1'b0));
    cfg_valid = 1'b0; rst = 1'b0;
    tick();

    // RFC 8439 block function vector, then the following block.
    ks_ready = 1'b1;
    start("rfc", rfc_k, rfc_n, 64'd1);
    wait_valid("rfc");
    check("rfc_ks_ctr", 512'(ks_ctr), 512'(64'd1));
`ifndef CHACHA_COUNTER64_EN
    check("rfc_word0",  512'(ks_data[0]),  512'(32'he4e7f110));
    check("rfc_word15", 512'(ks_data[15]), 512'(32'h4e3c50a2));
`endif
    wait_blocks("rfc", 2, 100);
    stop_stream("rfc");
    check_stream("rfc", rfc_k, rfc_n, 64'd1, 2);

    // Backpressure: first block held stable, second waits, then both drain in order.
    ks_ready = 1'b0;
    rand_cfg(rk, rn);
    start("bp", rk, rn, 64'd1);
    wait_valid("bp");
    held = ks_data;
    hold_bad = 1'b0;
    repeat (60) begin
      tick();
      if (!ks_valid || ks_data !== held || ks_ctr !== 64'd1) hold_bad = 1'b1;
    end
    check("bp_hold_stable", 512'(hold_bad), 512'(1'b0));
    check("bp_held_data", ks_data, ref_block(rk, rn, 64'd1));
    check("bp_none_taken", 512'(got_ctr.size()), 512'(0));
    ks_ready = 1'b1;
    wait_blocks("bp", 3, 100);
    stop_stream("bp");
    check_stream("bp", rk, rn, 64'd1, 3);

    // Stop during the round phase, then a fresh configuration.
    rand_cfg(rk, rn);
    start("stopr", rk, rn, 64'd7);
    repeat (11) tick();
    stop_stream("stopr");
    check("stopr_none", 512'(got_ctr.size()), 512'(0));
    start("stopr_rfc", rfc_k, rfc_n, 64'd1);
    wait_valid("stopr_rfc");
    wait_blocks("stopr_rfc", 1, 50);
    stop_stream("stopr_rfc");
    check_stream("stopr_rfc", rfc_k, rfc_n, 64'd1, 1);

    // Reset while a block waits behind a full buffer.
    ks_ready = 1'b0;
    rand_cfg(rk, rn);
    start("rstw", rk, rn, 64'd5);
    repeat (50) tick();
    check("rstw_buffer_full", 512'(ks_valid), 512'(1'b1));
    rst = 1'b1;
    tick();
    check("rstw_ks_valid",  512'(ks_valid),  512'(1'b0));
    check("rstw_cfg_ready", 512'(cfg_ready), 512'(1'b1));
    check("rstw_ks_ctr",    512'(ks_ctr),    512'(0));
    rst = 1'b0;
    tick();
    check("rstw_none", 512'(got_ctr.size()), 512'(0));
    ks_ready = 1'b1;
    start("rstw_rfc", rfc_k, rfc_n, 64'd1);
    wait_valid("rstw_rfc");
    wait_blocks("rstw_rfc", 1, 50);
    stop_stream("rstw_rfc");
    check_stream("rstw_rfc", rfc_k, rfc_n, 64'd1, 1);

`ifndef CHACHA_COUNTER64_EN
    // Counter exhaustion: exactly two blocks, then IDLE with ctr_wrap; upper ctr bits ignored.
    rand_cfg(rk, rn);
    c = {32'($urandom), 32'hFFFF_FFFE};
    start("wrap", rk, rn, c);
    n = 0;
    while (!(cfg_ready && !ks_valid && got_ctr.size() >= 2) && n < 200) begin
      tick();
      n++;
    end
    repeat (30) tick();
    check("wrap_ctr_wrap",  512'(ctr_wrap),  512'(1'b1));
    check("wrap_cfg_ready", 512'(cfg_ready), 512'(1'b1));
    check_stream("wrap", rk, rn, c, 2);
`else
    // 64-bit counter: carry from word 12 into word 13.
    rand_cfg(rk, rn);
    c = 64'h0000_0000_FFFF_FFFF;
    start("c64", rk, rn, c);
    wait_blocks("c64", 2, 100);
    stop_stream("c64");
    check("c64_second_ctr", 512'(got_ctr[1]), 512'(64'h1_0000_0000));
    check_stream("c64", rk, rn, c, 2);
`endif

    // Randomized streams with random consumer stalls.
    for (int it = 0; it < 3; it++) begin
      rand_cfg(rk, rn);
      c = 64'($urandom_range(0, 1000));
      start($sformatf("rnd%0d", it), rk, rn, c);
      tick();
      check($sformatf("rnd%0d_wrap_clear", it), 512'(ctr_wrap), 512'(1'b0));
      n = 0;
      while (got_ctr.size() < 4 && n < 400) begin
        ks_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      ks_ready = 1'b1;
      stop_stream($sformatf("rnd%0d", it));
      check_stream($sformatf("rnd%0d", it), rk, rn, c, 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
